// File: rtl/fetch_req_sched_pkg.sv
// rtl/fetch_req_sched_pkg.sv - shared types and constants for the fetch request scheduler
package fetch_req_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  localparam int FETCH_BYTES   = 8;
  localparam int PC_ALIGN_BITS = 3;

  function automatic logic [63:0] pc_align(input logic [63:0] pc);
    return {pc[63:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_req_sched_if.sv
// rtl/fetch_req_sched_if.sv - control, I-cache and fetch_fifo signals of the scheduler
interface fetch_req_sched_if #(
  parameter int PC_WIDTH = 32
);
  logic                fetch_enable;
  logic                branch_request;
  logic [PC_WIDTH-1:0] branch_pc;
  logic                icache_rd;
  logic [PC_WIDTH-1:0] icache_pc;
  logic                icache_accept;
  logic                icache_valid;
  logic [63:0]         icache_inst;
  logic                fifo_push;
  logic [63:0]         fifo_data;
  logic [PC_WIDTH-1:0] fifo_pc;
  logic                fifo_flush;
  logic                fifo_pop;

  modport master (
    input  fetch_enable, branch_request, branch_pc,
    input  icache_accept, icache_valid, icache_inst, fifo_pop,
    output icache_rd, icache_pc, fifo_push, fifo_data, fifo_pc, fifo_flush
  );

  modport slave (
    output fetch_enable, branch_request, branch_pc,
    output icache_accept, icache_valid, icache_inst, fifo_pop,
    input  icache_rd, icache_pc, fifo_push, fifo_data, fifo_pc, fifo_flush
  );
endinterface

// File: rtl/fetch_req_sched_pc_queue.sv
// rtl/fetch_req_sched_pc_queue.sv - in-order queue of PCs for accepted, unanswered reads
module fetch_req_sched_pc_queue #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic                pop,
  output logic [PC_WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // No count here: the owner's inflight counter guarantees no overflow or underflow.
  logic [PC_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pc;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_req_sched.sv
// rtl/fetch_req_sched.sv - credit-based I-cache fetch request scheduler feeding fetch_fifo
// Never issues a read whose response could overflow the FIFO; redirects flush and drop in-flight reads.
module fetch_req_sched
  import fetch_req_sched_pkg::*;
#(
  parameter int                PC_WIDTH     = 32,
  parameter int                FIFO_DEPTH   = 2,
  parameter int                MAX_INFLIGHT = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(32'h8000_0000)
) (
  input logic             clk,
  input logic             rst,
  fetch_req_sched_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + MAX_INFLIGHT + 1);

  fetch_state_e        state_q, state_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] head_pc;

  logic redirect;
  logic rd;
  logic accepted;
  logic resp;
  logic dropping;
  logic push;
  logic pop_eff;

  always_comb begin
    redirect = bus.branch_request;
    rd       = (state_q == FETCH) && !redirect
               && ((occ_q + inflight_q) < CNT_W'(FIFO_DEPTH))
               && (inflight_q < CNT_W'(MAX_INFLIGHT));
    accepted = rd && bus.icache_accept;
    // A response with nothing outstanding (e.g. arriving after reset) is ignored.
    resp     = bus.icache_valid && (inflight_q != '0);
    dropping = (drop_q != '0);
    push     = resp && !dropping && !redirect;
    pop_eff  = bus.fifo_pop && (occ_q != '0);
  end

  always_comb begin
    inflight_d = inflight_q + CNT_W'(accepted) - CNT_W'(resp);
    occ_d      = occ_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    if (redirect) begin
      occ_d  = '0;
      drop_d = inflight_d;
      pc_d   = PC_WIDTH'(pc_align(64'(bus.branch_pc)));
    end else begin
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop_eff);
      if (resp && dropping) drop_d = drop_q - 1'b1;
      if (accepted) pc_d = pc_q + PC_WIDTH'(FETCH_BYTES);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.fetch_enable) state_d = FETCH;
      end
      FETCH: begin
        if (!bus.fetch_enable)                 state_d = IDLE;
        else if (redirect && (drop_d != '0))   state_d = DRAIN;
      end
      DRAIN: begin
        if (drop_d == '0) state_d = bus.fetch_enable ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
    end
  end

  fetch_req_sched_pc_queue #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (MAX_INFLIGHT)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (accepted),
    .push_pc (pc_q),
    .pop     (resp),
    .head    (head_pc)
  );

  assign bus.icache_rd  = rd;
  assign bus.icache_pc  = pc_q;
  assign bus.fifo_push  = push;
  assign bus.fifo_data  = bus.icache_inst;
  assign bus.fifo_pc    = head_pc;
  assign bus.fifo_flush = redirect;

endmodule
